noc_output_port_sched: RTL and testbench

- Per-output-port packet scheduler for the mesh router.
- Arbitrates the five router input ports (0..4) for one output port and locks the grant for a whole packet, from head flit to tail flit.
- Gates flit transfer on downstream buffer credits and drives the crossbar select for its output.
- One instance sits on each output port, between the input buffers and the crossbar.

---
 rtl/noc_output_port_sched.sv | 170 +++++++++++++++++
 tb/tb_noc_output_port_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_port_sched.sv
// Per-output-port packet scheduler for the mesh router.
// Round-robin arbitration over five input ports, with the grant locked from head
// flit to tail flit. Flit transfer is gated on downstream credits, and the block
// drives the crossbar select for its output.
module noc_output_port_sched #(
  parameter int NUM_IN = 5,
  parameter int DEPTH  = 4,
  parameter int CW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] valid_in,
  input  logic [NUM_IN-1:0] tail_in,
  input  logic              credit_in,
  output logic [NUM_IN-1:0] gnt,
  output logic [2:0]        sel,
  output logic              fire,
  output logic [CW-1:0]     credit_cnt,
  output logic              busy,
  output logic              cred_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [CW-1:0] CRED_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CRED_ONE  = CW'(1);
  localparam logic [CW-1:0] CRED_ZERO = CW'(0);
  localparam logic [2:0]    LAST_IDX  = 3'(NUM_IN - 1);

  state_t              state_r;
  logic [2:0]          owner_r;
  logic [2:0]          rr_ptr_r;
  logic [NUM_IN-1:0]   gnt_r;
  logic [2:0]          sel_r;
  logic                busy_r;
  logic [CW-1:0]       credit_cnt_r;
  logic                cred_err_r;

  logic [2:0]          scan_idx_s;
  logic [2:0]          win_idx_s;
  logic                win_vld_s;
  logic                fire_s;
  logic                release_s;
  logic [CW-1:0]       credit_nxt_s;
  logic                cred_ovf_s;

  // Advance an input index by one, wrapping from the last port back to port 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == LAST_IDX) ? 3'd0 : v + 3'd1;
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping past the last port.
  always_comb begin
    win_vld_s  = 1'b0;
    win_idx_s  = 3'd0;
    scan_idx_s = rr_ptr_r;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!win_vld_s && req[scan_idx_s]) begin
        win_vld_s = 1'b1;
        win_idx_s = scan_idx_s;
      end else begin
        win_vld_s = win_vld_s;
      end
      scan_idx_s = wrap_inc(scan_idx_s);
    end
  end

  // The owner's flit moves only while locked and a downstream slot is free.
  always_comb begin
    fire_s    = 1'b0;
    release_s = 1'b0;
    if (state_r == LOCK && !rst) begin
      fire_s    = valid_in[owner_r] && (credit_cnt_r != CRED_ZERO);
      release_s = fire_s && tail_in[owner_r];
    end else begin
      fire_s    = 1'b0;
      release_s = 1'b0;
    end
  end

  // Next credit count. Simultaneous spend and return cancel out; a return while full flags an overflow.
  always_comb begin
    credit_nxt_s = credit_cnt_r;
    cred_ovf_s   = 1'b0;
    if (fire_s && !credit_in) begin
      credit_nxt_s = credit_cnt_r - CRED_ONE;
    end else if (credit_in && !fire_s) begin
      if (credit_cnt_r == CRED_FULL) begin
        cred_ovf_s = 1'b1;
      end else begin
        credit_nxt_s = credit_cnt_r + CRED_ONE;
      end
    end else begin
      credit_nxt_s = credit_cnt_r;
    end
  end

  // Packet-lock FSM with registered grant, select and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      owner_r  <= 3'd0;
      rr_ptr_r <= 3'd0;
      gnt_r    <= '0;
      sel_r    <= 3'd0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_vld_s) begin
            state_r  <= LOCK;
            owner_r  <= win_idx_s;
            rr_ptr_r <= wrap_inc(win_idx_s);
            gnt_r    <= NUM_IN'(1) << win_idx_s;
            sel_r    <= win_idx_s;
            busy_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
            gnt_r   <= '0;
            sel_r   <= 3'd0;
            busy_r  <= 1'b0;
          end
        end
        LOCK: begin
          if (release_s) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            sel_r   <= 3'd0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= LOCK;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          sel_r   <= 3'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Downstream credit counter and sticky overflow flag; both persist across packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt_r <= CRED_FULL;
      cred_err_r   <= 1'b0;
    end else begin
      credit_cnt_r <= credit_nxt_s;
      if (cred_ovf_s) begin
        cred_err_r <= 1'b1;
      end else begin
        cred_err_r <= cred_err_r;
      end
    end
  end

  assign gnt        = gnt_r;
  assign sel        = sel_r;
  assign busy       = busy_r;
  assign fire       = fire_s;
  assign credit_cnt = credit_cnt_r;
  assign cred_err   = cred_err_r;

endmodule

// File: tb/tb_noc_output_port_sched.sv
// Testbench for noc_output_port_sched.
// A packet-level reference model is compared against the DUT on every cycle,
// and hand-computed literal checks pin the scenarios.
module tb_noc_output_port_sched;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req, valid_in, tail_in;
  logic       credit_in;
  logic [4:0] gnt;
  logic [2:0] sel;
  logic       fire;
  logic [2:0] credit_cnt;
  logic       busy;
  logic       cred_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit m_valid = 1'b0;
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cred;
  bit m_err;

  noc_output_port_sched #(.NUM_IN(5), .DEPTH(DEPTH), .CW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .valid_in(valid_in), .tail_in(tail_in),
    .credit_in(credit_in), .gnt(gnt), .sel(sel), .fire(fire),
    .credit_cnt(credit_cnt), .busy(busy), .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer happens when the packet owner presents a flit and a credit is available.
  function automatic bit model_fire();
    return m_locked && valid_in[m_owner] && (m_cred > 0) && !rst;
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic compare_all();
    chk("gnt",        32'(gnt),        m_locked ? (32'd1 << m_owner) : 32'd0);
    chk("sel",        32'(sel),        m_locked ? 32'(m_owner) : 32'd0);
    chk("busy",       32'(busy),       32'(m_locked));
    chk("fire",       32'(fire),       32'(model_fire()));
    chk("credit_cnt", 32'(credit_cnt), 32'(m_cred));
    chk("cred_err",   32'(cred_err),   32'(m_err));
  endtask

  // Advance the model by one clock using the inputs that are being applied now.
  task automatic model_step();
    bit f;
    f = model_fire();
    if (rst) begin
      m_valid  = 1'b1;
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
      m_cred   = DEPTH;
      m_err    = 1'b0;
    end else begin
      if (f && !credit_in) m_cred = m_cred - 1;
      else if (credit_in && !f) begin
        if (m_cred == DEPTH) m_err = 1'b1;
        else m_cred = m_cred + 1;
      end
      if (!m_locked) begin
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (m_ptr + k) % 5;
          if (!m_locked && req[i]) begin
            m_locked = 1'b1;
            m_owner  = i;
            m_ptr    = (i + 1) % 5;
          end
        end
      end else if (f && tail_in[m_owner]) begin
        m_locked = 1'b0;
      end
    end
  endtask

  // One cycle: settle, compare, update model, wait past the active edge.
  task automatic tick();
    #1;
    if (m_valid) compare_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] v, input logic [4:0] t, input logic c);
    req = r; valid_in = v; tail_in = t; credit_in = c;
  endtask

  logic [4:0] order [5];

  initial begin
    order[0] = 5'b00001; order[1] = 5'b00010; order[2] = 5'b00100;
    order[3] = 5'b01000; order[4] = 5'b10000;

    rst = 1'b1;
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk("reset_gnt",  32'(gnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cred", 32'(credit_cnt), 32'd4);
    chk("reset_err",  32'(cred_err), 32'd0);

    // Single requester on port 2.
    drive(5'b00100, 5'b0, 5'b0, 1'b0);
    tick();
    chk("t1_gnt",  32'(gnt), 32'b00100);
    chk("t1_sel",  32'(sel), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    drive(5'b0, 5'b00100, 5'b00100, 1'b0);
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick();
    // rr_ptr is now 3, so full request grants port 3.
    drive(5'b11111, 5'b0, 5'b0, 1'b0);
    tick();
    chk("t1_rrptr3", 32'(gnt), 32'b01000);
    drive(5'b0, 5'b01000, 5'b01000, 1'b0);
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick();
    rst = 1'b1;
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Five single-flit packets under full request: order 0..4, one idle cycle between.
    for (int k = 0; k < 5; k++) begin
      chk("rr_idle_gap", 32'(gnt), 32'd0);
      drive(5'b11111, 5'b0, 5'b0, 1'b0);
      tick();
      chk("rr_order", 32'(gnt), 32'(order[k]));
      drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
      tick();
    end
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick();
    chk("rr_cred", 32'(credit_cnt), 32'd4);

    // Port 1 sends a 6-flit packet with credits exhausted after 4 flits.
    drive(5'b00010, 5'b0, 5'b0, 1'b0);
    tick();
    chk("t3_gnt", 32'(gnt), 32'b00010);
    drive(5'b0, 5'b00010, 5'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("t3_cred0", 32'(credit_cnt), 32'd0);
    #1;
    chk("t3_fire_blocked", 32'(fire), 32'd0);
    tick(); tick(); tick();
    chk("t3_held", 32'(gnt), 32'b00010);
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick(); tick();
    chk("t3_cred2", 32'(credit_cnt), 32'd2);
    drive(5'b0, 5'b00010, 5'b0, 1'b0);
    tick();
    drive(5'b0, 5'b00010, 5'b00010, 1'b0);
    tick();
    chk("t3_release", 32'(gnt), 32'd0);
    chk("t3_cred_end", 32'(credit_cnt), 32'd0);

    // Credits back to 2, then spend and return in the same cycle.
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick(); tick();
    drive(5'b00100, 5'b0, 5'b0, 1'b0);
    tick();
    chk("t4_gnt", 32'(gnt), 32'b00100);
    drive(5'b0, 5'b00100, 5'b0, 1'b1);
    tick();
    chk("t4_cred_same", 32'(credit_cnt), 32'd2);
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick(); tick(); tick();
    chk("t4_cred_full", 32'(credit_cnt), 32'd4);
    chk("t4_err_set", 32'(cred_err), 32'd1);
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick();
    chk("t4_err_sticky", 32'(cred_err), 32'd1);
    drive(5'b0, 5'b00100, 5'b00100, 1'b0);
    tick();

    // Port 3 packet; req changes during lock are ignored.
    drive(5'b01000, 5'b0, 5'b0, 1'b0);
    tick();
    drive(5'b00001, 5'b01000, 5'b0, 1'b0);
    tick();
    chk("t5_hold_a", 32'(gnt), 32'b01000);
    drive(5'b00001, 5'b0, 5'b0, 1'b0);
    tick();
    chk("t5_hold_b", 32'(gnt), 32'b01000);
    drive(5'b00001, 5'b01000, 5'b01000, 1'b0);
    tick();
    chk("t5_idle", 32'(gnt), 32'd0);
    drive(5'b00001, 5'b0, 5'b0, 1'b0);
    tick();
    chk("t5_next", 32'(gnt), 32'b00001);
    chk("t5_cred1", 32'(credit_cnt), 32'd1);

    // Reset mid-packet.
    rst = 1'b1;
    drive(5'b0, 5'b00001, 5'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("t6_gnt",  32'(gnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cred", 32'(credit_cnt), 32'd4);
    chk("t6_err",  32'(cred_err), 32'd0);
    drive(5'b11111, 5'b0, 5'b0, 1'b0);
    tick();
    chk("t6_rr0", 32'(gnt), 32'b00001);
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
